// File: rtl/cv_uart_pkg.sv
// Shared constants and types for the parametrised UART receive path.
package cv_uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_PARITY  = 3'd3,
        ST_STOP    = 3'd4,
        ST_WAIT_HI = 3'd5
    } rx_state_t;

    // A stored frame is {frm_err, par_err, data}.
    function automatic int entry_width(input int data_w);
        return data_w + 2;
    endfunction

endpackage

// File: rtl/cv_sync_fifo.sv
// Show-ahead synchronous FIFO with ready/valid on both sides and an exact fill level.
module cv_sync_fifo #(
    parameter int W  = 10,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [W-1:0]  wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [W-1:0]  rd_data,
    output logic [AW:0]   level
);

    localparam int         DEPTH    = 2 ** AW;
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   cnt_r;
    logic          do_push_s;
    logic          do_pop_s;

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign rd_valid  = (cnt_r != {(AW + 1){1'b0}});
    assign wr_ready  = (cnt_r != FULL_LVL) || rd_ready;
    assign do_pop_s  = rd_valid && rd_ready;
    assign do_push_s = wr_valid && wr_ready;
    assign rd_data   = mem_r[rd_ptr_r];
    assign level     = cnt_r;

    // Pointer and level bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            cnt_r    <= {(AW + 1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   cnt_r <= cnt_r + (AW + 1)'(1);
                2'b01:   cnt_r <= cnt_r - (AW + 1)'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Storage, cleared so the head reads zero out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

endmodule

// File: rtl/cv_uart_rx_fifo.sv
// Oversampling UART receiver with per-frame error flags, receive FIFO and sticky overrun.
// Optional build macro CV_UART_ERR_INJECT_EN adds INJ_PAR/INJ_FRM error-injection inputs.
module cv_uart_rx_fifo #(
    parameter int DATA_W   = 8,
    parameter int PAR_MODE = 1,
    parameter int OVS      = 16,
    parameter int FIFO_AW  = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CE,
    input  logic              RXD,
    output logic [DATA_W-1:0] RX_DATA,
    output logic              RX_PAR_ERR,
    output logic              RX_FRM_ERR,
    output logic              RX_VALID,
    input  logic              RX_READY,
`ifdef CV_UART_ERR_INJECT_EN
    input  logic              INJ_PAR,
    input  logic              INJ_FRM,
`endif
    output logic              OVR_ERR,
    input  logic              OVR_CLR,
    output logic [FIFO_AW:0]  FIFO_LVL
);

    import cv_uart_pkg::*;

    localparam int               ENT_W    = entry_width(DATA_W);
    localparam int               CNT_W    = $clog2(OVS);
    localparam int               BIT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(OVS / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(OVS - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic             HAS_PAR  = (PAR_MODE != int'(PAR_NONE));

    function automatic logic par_err_calc(input logic [DATA_W-1:0] d, input logic b);
        logic x;
        x = (^d) ^ b;
        if (PAR_MODE == int'(PAR_ODD)) begin
            return ~x;
        end else if (PAR_MODE == int'(PAR_EVEN)) begin
            return x;
        end else begin
            return 1'b0;
        end
    endfunction

    rx_state_t         state_r;
    rx_state_t         nxt_state_s;
    logic              sync1_r;
    logic              sync2_r;
    logic [CNT_W-1:0]  tick_cnt_r;
    logic [BIT_W-1:0]  bit_cnt_r;
    logic [DATA_W-1:0] shreg_r;
    logic              par_err_r;
    logic              push_r;
    logic [DATA_W-1:0] ent_data_r;
    logic              ent_par_r;
    logic              ent_frm_r;
    logic              ovr_r;
    logic              half_hit_s;
    logic              full_hit_s;
    logic              cnt_clr_s;
    logic              bit_clr_s;
    logic              shift_en_s;
    logic              par_cap_s;
    logic              stop_cap_s;
    logic              inj_par_s;
    logic              inj_frm_s;
    logic              fifo_wr_ready_s;
    logic [ENT_W-1:0]  fifo_wr_data_s;
    logic [ENT_W-1:0]  fifo_rd_data_s;

`ifdef CV_UART_ERR_INJECT_EN
    assign inj_par_s = INJ_PAR & HAS_PAR;
    assign inj_frm_s = INJ_FRM;
`else
    assign inj_par_s = 1'b0;
    assign inj_frm_s = 1'b0;
`endif

    assign half_hit_s = CE && (tick_cnt_r == HALF_M1);
    assign full_hit_s = CE && (tick_cnt_r == FULL_M1);

    // Line synchroniser, preset to the idle level.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= RXD;
            sync2_r <= sync1_r;
        end
    end

    // Receiver state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= nxt_state_s;
        end
    end

    // Receiver next-state logic; every decision waits for an oversample tick.
    always_comb begin
        nxt_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (CE && !sync2_r) nxt_state_s = ST_START;
                else                nxt_state_s = ST_IDLE;
            end
            ST_START: begin
                if (half_hit_s) nxt_state_s = sync2_r ? ST_IDLE : ST_DATA;
                else            nxt_state_s = ST_START;
            end
            ST_DATA: begin
                if (full_hit_s && (bit_cnt_r == LAST_BIT)) nxt_state_s = HAS_PAR ? ST_PARITY : ST_STOP;
                else                                       nxt_state_s = ST_DATA;
            end
            ST_PARITY: begin
                if (full_hit_s) nxt_state_s = ST_STOP;
                else            nxt_state_s = ST_PARITY;
            end
            ST_STOP: begin
                if (full_hit_s) nxt_state_s = sync2_r ? ST_IDLE : ST_WAIT_HI;
                else            nxt_state_s = ST_STOP;
            end
            ST_WAIT_HI: begin
                if (CE && sync2_r) nxt_state_s = ST_IDLE;
                else               nxt_state_s = ST_WAIT_HI;
            end
            default: nxt_state_s = ST_IDLE;
        endcase
    end

    // Receiver datapath controls decoded from the current state.
    always_comb begin
        cnt_clr_s  = 1'b0;
        bit_clr_s  = 1'b0;
        shift_en_s = 1'b0;
        par_cap_s  = 1'b0;
        stop_cap_s = 1'b0;
        case (state_r)
            ST_IDLE:    begin cnt_clr_s = 1'b1;       bit_clr_s  = 1'b1;       end
            ST_START:   begin cnt_clr_s = half_hit_s; bit_clr_s  = 1'b1;       end
            ST_DATA:    begin cnt_clr_s = full_hit_s; shift_en_s = full_hit_s; end
            ST_PARITY:  begin cnt_clr_s = full_hit_s; par_cap_s  = full_hit_s; end
            ST_STOP:    begin cnt_clr_s = full_hit_s; stop_cap_s = full_hit_s; end
            ST_WAIT_HI: begin cnt_clr_s = 1'b1;                                end
            default:    begin cnt_clr_s = 1'b1;       bit_clr_s  = 1'b1;       end
        endcase
    end

    // Tick counter, bit counter, LSB-first shifter and parity check.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tick_cnt_r <= {CNT_W{1'b0}};
            bit_cnt_r  <= {BIT_W{1'b0}};
            shreg_r    <= {DATA_W{1'b0}};
            par_err_r  <= 1'b0;
        end else begin
            if (cnt_clr_s) begin
                tick_cnt_r <= {CNT_W{1'b0}};
            end else if (CE) begin
                tick_cnt_r <= tick_cnt_r + CNT_W'(1);
            end
            if (bit_clr_s) begin
                bit_cnt_r <= {BIT_W{1'b0}};
                par_err_r <= 1'b0;
            end else if (shift_en_s) begin
                bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                shreg_r   <= {sync2_r, shreg_r[DATA_W-1:1]};
            end else if (par_cap_s) begin
                par_err_r <= par_err_calc(shreg_r, sync2_r);
            end
        end
    end

    // Completed frame is staged and pushed on the cycle after the stop sample.
    always_ff @(posedge CLK) begin
        if (RST) begin
            push_r     <= 1'b0;
            ent_data_r <= {DATA_W{1'b0}};
            ent_par_r  <= 1'b0;
            ent_frm_r  <= 1'b0;
        end else begin
            push_r <= stop_cap_s;
            if (stop_cap_s) begin
                ent_data_r <= shreg_r;
                ent_par_r  <= par_err_r;
                ent_frm_r  <= ~sync2_r;
            end
        end
    end

    assign fifo_wr_data_s = {ent_frm_r ^ inj_frm_s, ent_par_r ^ inj_par_s, ent_data_r};

    cv_sync_fifo #(
        .W  (ENT_W),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk      (CLK),
        .rst      (RST),
        .wr_valid (push_r),
        .wr_ready (fifo_wr_ready_s),
        .wr_data  (fifo_wr_data_s),
        .rd_valid (RX_VALID),
        .rd_ready (RX_READY),
        .rd_data  (fifo_rd_data_s),
        .level    (FIFO_LVL)
    );

    // Sticky overrun: a dropped frame outranks a simultaneous clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ovr_r <= 1'b0;
        end else if (push_r && !fifo_wr_ready_s) begin
            ovr_r <= 1'b1;
        end else if (OVR_CLR) begin
            ovr_r <= 1'b0;
        end
    end

    assign OVR_ERR    = ovr_r;
    assign RX_DATA    = fifo_rd_data_s[DATA_W-1:0];
    assign RX_PAR_ERR = fifo_rd_data_s[DATA_W];
    assign RX_FRM_ERR = fifo_rd_data_s[DATA_W+1];

endmodule

// File: tb/tb_cv_uart_rx_fifo.sv
// Scoreboard bench for cv_uart_rx_fifo in 8E1, OVS=16, 4-entry FIFO configuration.
module tb_cv_uart_rx_fifo;

    localparam int OVS = 16;

    logic       CLK;
    logic       RST;
    logic       CE;
    logic       RXD;
    logic [7:0] RX_DATA;
    logic       RX_PAR_ERR;
    logic       RX_FRM_ERR;
    logic       RX_VALID;
    logic       RX_READY;
    logic       OVR_ERR;
    logic       OVR_CLR;
    logic [2:0] FIFO_LVL;
`ifdef CV_UART_ERR_INJECT_EN
    logic       INJ_PAR;
    logic       INJ_FRM;
`endif

    int         checks = 0;
    int         errors = 0;
    logic [9:0] exp_q[$];

    cv_uart_rx_fifo #(
        .DATA_W   (8),
        .PAR_MODE (1),
        .OVS      (OVS),
        .FIFO_AW  (2)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .CE         (CE),
        .RXD        (RXD),
        .RX_DATA    (RX_DATA),
        .RX_PAR_ERR (RX_PAR_ERR),
        .RX_FRM_ERR (RX_FRM_ERR),
        .RX_VALID   (RX_VALID),
        .RX_READY   (RX_READY),
`ifdef CV_UART_ERR_INJECT_EN
        .INJ_PAR    (INJ_PAR),
        .INJ_FRM    (INJ_FRM),
`endif
        .OVR_ERR    (OVR_ERR),
        .OVR_CLR    (OVR_CLR),
        .FIFO_LVL   (FIFO_LVL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    task automatic push_exp(input logic frm, input logic par, input logic [7:0] d);
        exp_q.push_back({frm, par, d});
    endtask

    task automatic tick();
        @(negedge CLK);
        CE = 1'b1;
        @(negedge CLK);
        CE = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        @(negedge CLK);
        RXD = b;
        repeat (OVS) tick();
    endtask

    task automatic idle_bits(input int n);
        @(negedge CLK);
        RXD = 1'b1;
        repeat (n * OVS) tick();
    endtask

    // mode 0: plain; 1: check push latency; 2: pop in the push cycle.
    task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_b, input int mode);
        logic pb;
        pb = (^d) ^ par_flip;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(pb);
        @(negedge CLK);
        RXD = stop_b;
        for (int i = 0; i < OVS; i++) begin
            tick();
            // The stop bit is sampled on its 10th tick (2-FF sync + half-bit offset).
            if (i == 9) begin
                if (mode == 1) begin
                    check("valid_low_at_push", 32'(RX_VALID), 32'd0);
                    @(negedge CLK);
                    check("valid_2clk_after_stop", 32'(RX_VALID), 32'd1);
                end else if (mode == 2) begin
                    RX_READY = 1'b1;
                    @(negedge CLK);
                    RX_READY = 1'b0;
                end
            end
        end
    endtask

    task automatic drain(input string name);
        RX_READY = 1'b1;
        for (int i = 0; i < 20 && FIFO_LVL != 3'd0; i++) @(negedge CLK);
        @(negedge CLK);
        check({name, "_lvl0"}, 32'(FIFO_LVL), 32'd0);
        check({name, "_q_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: every handshake pops the scoreboard and compares the head entry.
    initial begin
        logic [9:0] got;
        logic [9:0] want;
        forever begin
            @(negedge CLK);
            #1;
            if (!RST && RX_VALID && RX_READY) begin
                got = {RX_FRM_ERR, RX_PAR_ERR, RX_DATA};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pop_unexpected: got 0x%0h, expected no entry", got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        errors++;
                        $display("FAIL pop_entry: got 0x%0h, expected 0x%0h", got, want);
                    end
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST      = 1'b1;
        CE       = 1'b0;
        RXD      = 1'b1;
        RX_READY = 1'b1;
        OVR_CLR  = 1'b0;
`ifdef CV_UART_ERR_INJECT_EN
        INJ_PAR  = 1'b0;
        INJ_FRM  = 1'b0;
`endif
        repeat (3) @(negedge CLK);
        check("rst_valid", 32'(RX_VALID), 32'd0);
        check("rst_lvl", 32'(FIFO_LVL), 32'd0);
        check("rst_ovr", 32'(OVR_ERR), 32'd0);
        check("rst_head", 32'({RX_FRM_ERR, RX_PAR_ERR, RX_DATA}), 32'd0);
        RST = 1'b0;
        idle_bits(1);

        // 1: clean 8E1 frame with latency check
        push_exp(1'b0, 1'b0, 8'h41);
        send_frame(8'h41, 1'b0, 1'b1, 1);
        idle_bits(1);
        check("t1_q_empty", 32'(exp_q.size()), 32'd0);

        // 2: wrong parity bit
        push_exp(1'b0, 1'b1, 8'h03);
        send_frame(8'h03, 1'b1, 1'b1, 0);
        idle_bits(1);
        check("t2_q_empty", 32'(exp_q.size()), 32'd0);

        // 3: stop bit low, break held, then recovery
        push_exp(1'b1, 1'b0, 8'h55);
        send_frame(8'h55, 1'b0, 1'b0, 0);
        repeat (2 * OVS) tick();
        check("t3_one_entry", 32'(exp_q.size()), 32'd0);
        check("t3_lvl_in_break", 32'(FIFO_LVL), 32'd0);
        idle_bits(2);
        push_exp(1'b0, 1'b0, 8'h12);
        send_frame(8'h12, 1'b0, 1'b1, 0);
        idle_bits(1);
        check("t3_q_empty", 32'(exp_q.size()), 32'd0);

        // 4: start glitch is rejected
        @(negedge CLK);
        RXD = 1'b0;
        repeat (4) tick();
        idle_bits(3);
        check("t4_lvl", 32'(FIFO_LVL), 32'd0);
        check("t4_q_empty", 32'(exp_q.size()), 32'd0);

        // 5a: overflow with no reader
        RX_READY = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            push_exp(1'b0, 1'b0, 8'(i));
            send_frame(8'(i), 1'b0, 1'b1, 0);
        end
        idle_bits(1);
        check("t5_lvl_full", 32'(FIFO_LVL), 32'd4);
        check("t5_no_ovr_yet", 32'(OVR_ERR), 32'd0);
        send_frame(8'h05, 1'b0, 1'b1, 0);
        idle_bits(1);
        check("t5_ovr_set", 32'(OVR_ERR), 32'd1);
        check("t5_lvl_still4", 32'(FIFO_LVL), 32'd4);
        drain("t5a");
        check("t5_ovr_sticky", 32'(OVR_ERR), 32'd1);
        @(negedge CLK);
        OVR_CLR = 1'b1;
        @(negedge CLK);
        OVR_CLR = 1'b0;
        check("t5_ovr_clr", 32'(OVR_ERR), 32'd0);

        // 5b: pop coincides with the fifth push
        RX_READY = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            push_exp(1'b0, 1'b0, 8'(i));
            send_frame(8'(i), 1'b0, 1'b1, (i == 5) ? 2 : 0);
        end
        idle_bits(1);
        check("t5b_no_ovr", 32'(OVR_ERR), 32'd0);
        check("t5b_lvl", 32'(FIFO_LVL), 32'd4);
        drain("t5b");

        // 6: reset in the middle of a frame
        RX_READY = 1'b0;
        push_exp(1'b0, 1'b0, 8'h33);
        send_frame(8'h33, 1'b0, 1'b1, 0);
        idle_bits(1);
        check("t6_lvl_before", 32'(FIFO_LVL), 32'd1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        @(negedge CLK);
        RST = 1'b1;
        RXD = 1'b1;
        repeat (2) @(negedge CLK);
        exp_q.delete();
        check("t6_rst_valid", 32'(RX_VALID), 32'd0);
        check("t6_rst_lvl", 32'(FIFO_LVL), 32'd0);
        RST = 1'b0;
        RX_READY = 1'b1;
        idle_bits(2);
`ifdef CV_UART_ERR_INJECT_EN
        INJ_FRM = 1'b1;
        push_exp(1'b1, 1'b0, 8'hA5);
`else
        push_exp(1'b0, 1'b0, 8'hA5);
`endif
        send_frame(8'hA5, 1'b0, 1'b1, 0);
        idle_bits(1);
        check("t6_q_empty", 32'(exp_q.size()), 32'd0);
        check("t6_lvl_end", 32'(FIFO_LVL), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
